// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Load-use stall, multi-cycle multiply freeze with watchdog, and
//            branch/jump flush sequencing for a five-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MULT_TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_EX_mem_read,
    input  logic [4:0]  ID_EX_rt,
    input  logic [4:0]  IF_ID_rs,
    input  logic [4:0]  IF_ID_rt,
    input  logic        IF_ID_uses_rt,
    input  logic        mult_start,
    input  logic        mult_done,
    input  logic        branch_taken,
    input  logic        jump,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_write,
    output logic        ID_EX_bubble,
    output logic        EX_MEM_bubble,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
    output logic        mult_timeout
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_MULT_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0]  C_LOAD_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0]  C_WDOG_LAST   = 8'(MULT_TIMEOUT - 1);
    localparam logic [15:0] C_CNT_MAX     = 16'hFFFF;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [7:0]  r_wdog;
    logic [7:0]  w_wdog_next;
    logic        r_mult_timeout;
    logic        w_timeout_set;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    logic        w_hazard;
    logic        w_pc_write;
    logic        w_if_id_write;
    logic        w_if_id_flush;
    logic        w_id_ex_write;
    logic        w_id_ex_bubble;
    logic        w_ex_mem_bubble;

    assign w_hazard = ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
                      ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_RUN;
            r_cnt          <= 4'd0;
            r_wdog         <= 8'd0;
            r_mult_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_wdog  <= w_wdog_next;
            if (w_timeout_set) begin
                r_mult_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_cnt_next      = r_cnt;
        w_wdog_next     = r_wdog;
        w_timeout_set   = 1'b0;
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_write   = 1'b1;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;

        case (r_state)
            S_RUN: begin
                if (mult_start) begin
                    w_next_state = S_MULT_WAIT;
                    w_wdog_next  = 8'd0;
                end else if (w_hazard) begin
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    // A single-cycle stall is fully covered by this Mealy cycle.
                    if (LOAD_STALL_CYCLES > 1) begin
                        w_cnt_next   = C_LOAD_RELOAD;
                        w_next_state = S_LOAD_STALL;
                    end
                end else if (branch_taken || jump) begin
                    w_if_id_flush = 1'b1;
                end
            end

            S_LOAD_STALL: begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
                w_cnt_next     = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next_state = S_RUN;
                end
            end

            S_MULT_WAIT: begin
                w_pc_write      = 1'b0;
                w_if_id_write   = 1'b0;
                w_id_ex_write   = 1'b0;
                w_ex_mem_bubble = 1'b1;
                w_wdog_next     = r_wdog + 8'd1;
                if (mult_done) begin
                    w_next_state = S_RUN;
                end else if (r_wdog == C_WDOG_LAST) begin
                    w_next_state  = S_RUN;
                    w_timeout_set = 1'b1;
                end
            end

            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // Reset forces the pipeline-enable defaults regardless of input activity.
    always_comb begin
        pc_write      = w_pc_write    | ~rst_n;
        IF_ID_write   = w_if_id_write | ~rst_n;
        ID_EX_write   = w_id_ex_write | ~rst_n;
        IF_ID_flush   = w_if_id_flush   & rst_n;
        ID_EX_bubble  = w_id_ex_bubble  & rst_n;
        EX_MEM_bubble = w_ex_mem_bubble & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else begin
            if (!pc_write && (r_stall_count != C_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (IF_ID_flush && (r_flush_count != C_CNT_MAX)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_count  = r_stall_count;
    assign flush_count  = r_flush_count;
    assign mult_timeout = r_mult_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Directed scoreboard bench; instance A uses default parameters,
//            instance B uses a 3-cycle load stall and a 4-cycle watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    // Control vector bit order:
    // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble, mult_timeout}
    localparam logic [6:0] C_DEF    = 7'b1101000;
    localparam logic [6:0] C_LSTALL = 7'b0001100;
    localparam logic [6:0] C_FLUSH  = 7'b1111000;
    localparam logic [6:0] C_MULT   = 7'b0000010;

    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel_b;
    logic       mr, urt, ms, md, br, jp;
    logic [4:0] exrt, rs, rt;

    logic        a_pc, a_ifw, a_fl, a_idw, a_bub, a_exb, a_to;
    logic        b_pc, b_ifw, b_fl, b_idw, b_bub, b_exb, b_to;
    logic [15:0] a_sc, a_fc, b_sc, b_fc;

    logic [6:0]  obs_ctl;
    logic [15:0] obs_sc, obs_fc;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [15:0] exp_flush = 16'd0;
    logic        exp_to    = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .MULT_TIMEOUT(64)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_mem_read(mr & ~sel_b), .ID_EX_rt(exrt), .IF_ID_rs(rs), .IF_ID_rt(rt),
        .IF_ID_uses_rt(urt & ~sel_b), .mult_start(ms & ~sel_b), .mult_done(md & ~sel_b),
        .branch_taken(br & ~sel_b), .jump(jp & ~sel_b),
        .pc_write(a_pc), .IF_ID_write(a_ifw), .IF_ID_flush(a_fl), .ID_EX_write(a_idw),
        .ID_EX_bubble(a_bub), .EX_MEM_bubble(a_exb),
        .stall_count(a_sc), .flush_count(a_fc), .mult_timeout(a_to)
    );

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .MULT_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_mem_read(mr & sel_b), .ID_EX_rt(exrt), .IF_ID_rs(rs), .IF_ID_rt(rt),
        .IF_ID_uses_rt(urt & sel_b), .mult_start(ms & sel_b), .mult_done(md & sel_b),
        .branch_taken(br & sel_b), .jump(jp & sel_b),
        .pc_write(b_pc), .IF_ID_write(b_ifw), .IF_ID_flush(b_fl), .ID_EX_write(b_idw),
        .ID_EX_bubble(b_bub), .EX_MEM_bubble(b_exb),
        .stall_count(b_sc), .flush_count(b_fc), .mult_timeout(b_to)
    );

    assign obs_ctl = sel_b ? {b_pc, b_ifw, b_fl, b_idw, b_bub, b_exb, b_to}
                           : {a_pc, a_ifw, a_fl, a_idw, a_bub, a_exb, a_to};
    assign obs_sc  = sel_b ? b_sc : a_sc;
    assign obs_fc  = sel_b ? b_fc : a_fc;

    task automatic compare(input exp_t e);
        n_checks += 3;
        assert (obs_ctl === e.ctl) else begin
            n_err++;
            $error("FAIL %s ctl: observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
        end
        assert (obs_sc === e.sc) else begin
            n_err++;
            $error("FAIL %s stall_count: observed=%0d expected=%0d", e.tag, obs_sc, e.sc);
        end
        assert (obs_fc === e.fc) else begin
            n_err++;
            $error("FAIL %s flush_count: observed=%0d expected=%0d", e.tag, obs_fc, e.fc);
        end
    endtask

    task automatic drive(input logic i_mr, input logic [4:0] i_exrt, i_rs, i_rt,
                         input logic i_urt, i_ms, i_md, i_br, i_jp);
        mr = i_mr; exrt = i_exrt; rs = i_rs; rt = i_rt;
        urt = i_urt; ms = i_ms; md = i_md; br = i_br; jp = i_jp;
    endtask

    // One clock cycle: drive after the edge, queue expectation, compare at negedge.
    task automatic step(input string tag, input logic [6:0] ctl,
                        input logic i_mr, input logic [4:0] i_exrt, i_rs, i_rt,
                        input logic i_urt, i_ms, i_md, i_br, i_jp);
        exp_t e;
        @(posedge clk);
        #1;
        drive(i_mr, i_exrt, i_rs, i_rt, i_urt, i_ms, i_md, i_br, i_jp);
        e.tag = tag;
        e.ctl = ctl | {6'd0, exp_to};
        e.sc  = exp_stall;
        e.fc  = exp_flush;
        sb_q.push_back(e);
        if (!ctl[6] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        if (ctl[4]  && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
        @(negedge clk);
        compare(sb_q.pop_front());
    endtask

    task automatic idle(input string tag, input logic [6:0] ctl);
        step(tag, ctl, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_check(input string tag);
        exp_t e;
        e.tag = tag; e.ctl = C_DEF; e.sc = 16'd0; e.fc = 16'd0;
        sb_q.push_back(e);
        #1;
        compare(sb_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sel_b = 1'b0;
        rst_n = 1'b0;
        // Hazard and branch held during reset must not reach the outputs.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #12;
        reset_check("reset_hold");
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Instance A: single-cycle load stall, default watchdog.
        idle("a_idle", C_DEF);
        step("a_lu_rs", C_LSTALL, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("a_lu_done", C_DEF);
        step("a_rt_unused", C_DEF, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("a_r0", C_DEF, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("a_branch", C_FLUSH, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("a_jump", C_FLUSH, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("a_haz_br", C_LSTALL, 1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("a_idle2", C_DEF);
        step("a_mult_haz", C_DEF, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle("a_mult_wait", C_MULT);
        step("a_mult_done", C_MULT, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("a_after_mult", C_DEF);
        step("a_done_in_run", C_DEF, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Instance B: 3-cycle load stall, 4-cycle watchdog.
        sel_b     = 1'b1;
        exp_stall = 16'd0;
        exp_flush = 16'd0;
        idle("b_idle", C_DEF);
        step("b_lu_rt1", C_LSTALL, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("b_lu_rt2", C_LSTALL, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("b_lu_rt3", C_LSTALL, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("b_br_after", C_FLUSH, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("b_wd_start", C_DEF, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle("b_wd_wait", C_MULT);
        exp_to = 1'b1;
        idle("b_wd_exit", C_DEF);
        idle("b_wd_sticky", C_DEF);

        // Asynchronous reset in the middle of MULT_WAIT.
        step("b_m2_start", C_DEF, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("b_m2_wait", C_MULT);
        #2;
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        reset_check("b_async_rst");
        exp_to    = 1'b0;
        exp_stall = 16'd0;
        exp_flush = 16'd0;
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("b_m3_start", C_DEF, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("b_m3_wait", C_MULT);
        step("b_m3_done", C_MULT, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("b_m3_run", C_DEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
